// File: rtl/bicubic_result_streamer_pkg.sv
// Shared definitions for the bicubic result streamer: default widths,
// controller state encoding and the depth of the output skid FIFO.
package bicubic_result_streamer_pkg;

  localparam int ADDR_W_DEF = 14;  // ResultSRAM address width
  localparam int DATA_W_DEF = 8;   // pixel width
  localparam int DIM_W_DEF  = 6;   // TW/TH and x/y tag width
  localparam int CSUM_W_DEF = 16;  // checksum width

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/bicubic_result_streamer_pix_skid_fifo.sv
// pix_skid_fifo: small FIFO that absorbs SRAM read data while the pixel
// consumer stalls. Simultaneous push and pop are both honoured.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (control only)
//   push, push_data   write strobe and pixel to store
//   pop               remove the head entry
//   full, empty       occupancy flags
//   count             number of stored entries
//   head              oldest stored pixel (undefined while empty)
module pix_skid_fifo
  import bicubic_result_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [DATA_W-1:0]     head
);

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    count_d  = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bicubic_result_streamer.sv
// bicubic_result_streamer: after the scaler finishes, reads the TWxTH result
// image from ResultSRAM in raster order and streams it on a valid/ready pixel
// port with x/y/last tags, a running checksum and an end-of-frame done pulse.
// Ports:
//   CLK, RST          clock, synchronous active-low reset
//   start, TW, TH     frame launch pulse and target dimensions
//   sram_cen, sram_a  ResultSRAM read strobe (active-low) and address
//   sram_q            read data, valid the cycle after the address is issued
//   out_valid/ready   pixel handshake; out_data/out_x/out_y/out_last payload
//   busy, done        controller not idle / one-cycle end-of-frame pulse
//   checksum          sum of transferred pixels, wrapping
module bicubic_result_streamer
  import bicubic_result_streamer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int CSUM_W = CSUM_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  TW,
  input  logic [DIM_W-1:0]  TH,
  output logic              sram_cen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_x,
  output logic [DIM_W-1:0]  out_y,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum
);

  localparam int TOT_W = 2 * DIM_W;
  localparam int OCC_W = FIFO_CNT_W + 1;

  state_e                state_q, state_d;
  logic [DIM_W-1:0]      tw_q, tw_d, th_q, th_d;
  logic [DIM_W-1:0]      x_q, x_d, y_q, y_d;
  logic [TOT_W-1:0]      total_q, total_d, start_total;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic [CSUM_W-1:0]     csum_q, csum_d;
  logic                  fifo_full, fifo_empty, pop, issue;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_W-1:0]     fifo_head;
  logic [OCC_W-1:0]      occ;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [DATA_W-1:0] pix);
    return acc + CSUM_W'(pix);  // wraps modulo 2^CSUM_W
  endfunction

  pix_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (inflight_q),
    .push_data (sram_q),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    pop = ~fifo_empty & out_ready;
    occ = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    // Only issue when the word will find a free slot on its push edge, so a
    // full FIFO with a read still in flight can never arise.
    issue = (state_q == ST_RUN) && !(fifo_full && !pop) &&
            (occ < OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
    start_total = TOT_W'(TW) * TOT_W'(TH);

    state_d    = state_q;
    tw_d       = tw_q;
    th_d       = th_q;
    x_d        = x_q;
    y_d        = y_q;
    total_d    = total_q;
    rd_addr_d  = rd_addr_q;
    csum_d     = csum_q;
    inflight_d = issue;

    if (pop) begin
      csum_d = csum_add(csum_q, fifo_head);
      if (x_q == tw_q - DIM_W'(1)) begin
        x_d = '0;
        y_d = y_q + DIM_W'(1);
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tw_d      = TW;
          th_d      = TH;
          total_d   = start_total;
          rd_addr_d = '0;
          csum_d    = '0;
          x_d       = '0;
          y_d       = '0;
          state_d   = (start_total == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (rd_addr_q + ADDR_W'(1) == ADDR_W'(total_q)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the edge that completes the final transfer.
        if (!inflight_q && (fifo_empty || (fifo_count == FIFO_CNT_W'(1) && pop)))
          state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered so that done is high exactly while the controller sits in FIN.
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      tw_q       <= '0;
      th_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      total_q    <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      tw_q       <= tw_d;
      th_q       <= th_d;
      x_q        <= x_d;
      y_q        <= y_d;
      total_q    <= total_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      csum_q     <= csum_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign sram_cen  = ~issue;
  assign sram_a    = rd_addr_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_last  = out_valid && (x_q == tw_q - DIM_W'(1)) && (y_q == th_q - DIM_W'(1));
  assign done      = done_q;
  assign checksum  = csum_q;

endmodule

// File: tb/tb_bicubic_result_streamer.sv
// Bench for bicubic_result_streamer: a ResultSRAM model with one-cycle read
// latency on the inverted clock, directed and randomized frames, and an
// expected pixel stream derived from the raster-order definition of a frame.
module tb_bicubic_result_streamer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 6;
  localparam int CSUM_W = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  TW = '0;
  logic [DIM_W-1:0]  TH = '0;
  logic              sram_cen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_q = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [DIM_W-1:0]  out_x, out_y;
  logic              out_last, busy, done;
  logic [CSUM_W-1:0] checksum;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bicubic_result_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .CSUM_W(CSUM_W)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .TW(TW), .TH(TH),
    .sram_cen(sram_cen), .sram_a(sram_a), .sram_q(sram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 CLK = ~CLK;

  // ResultSRAM: address captured on the falling edge of the issue cycle,
  // data presented on the following falling edge.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              lat_en = 1'b0;
  logic [ADDR_W-1:0] lat_a  = '0;
  always @(negedge CLK) begin
    if (lat_en) sram_q <= mem[lat_a];
    lat_en <= (sram_cen === 1'b0);
    lat_a  <= sram_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);  // 1,0,0,1 repeating
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_reset_vals();
    check("rst_sram_cen", 32'(sram_cen), 32'd1);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
  endtask

  // fill: 0 = addr & 0xFF, 1 = all 0xFF, 2 = random.
  // restart_k: cycle at which a second start is pulsed (-1 none).
  // rst_after: stop after this many transfers so the caller can reset (-1 none).
  task automatic run_frame(input int tw, input int th, input int rmode, input int fill,
                           input int restart_k, input int rst_after);
    int          total, k, nx, issued, outstanding, max_out, last_k, done_k, exp_sum, budget;
    logic [31:0] exp_q[$];
    logic [31:0] want, obs, prev_obs;
    bit          seen_first, prev_stall, stop, pop;

    total = tw * th;
    for (int a = 0; a < total; a++) begin
      case (fill)
        0:       mem[a] = 8'(a & 255);
        1:       mem[a] = 8'hFF;
        default: mem[a] = 8'($urandom_range(0, 255));
      endcase
    end
    exp_sum = 0;
    for (int y = 0; y < th; y++)
      for (int x = 0; x < tw; x++) begin
        exp_sum += int'(mem[y * tw + x]);
        exp_q.push_back({11'b0, 1'(x == tw - 1 && y == th - 1), 6'(y), 6'(x), mem[y * tw + x]});
      end

    budget = 6 * total + 40;
    @(posedge CLK); #1;
    start = 1'b1; TW = DIM_W'(tw); TH = DIM_W'(th); out_ready = ready_for(rmode, 0);
    @(posedge CLK); #1;
    start = 1'b0; out_ready = ready_for(rmode, 1);

    k = 1; nx = 0; issued = 0; outstanding = 0; max_out = 0; last_k = 0; done_k = -1;
    seen_first = 0; prev_stall = 0; stop = 0; prev_obs = '0;
    while (!stop && k <= budget) begin
      @(negedge CLK);
      pop = out_valid && out_ready;
      if (sram_cen === 1'b0) begin
        issued++;
        outstanding++;
      end
      if (pop) outstanding--;
      if (outstanding > max_out) max_out = outstanding;
      if (k == 1) check("busy_in_frame", 32'(busy), 32'd1);
      if (out_valid && !seen_first) begin
        seen_first = 1;
        check("first_valid_cycle", k, 3);
      end
      obs = {10'b0, out_valid, out_last, out_y, out_x, out_data};
      if (prev_stall) check("stall_hold", obs, prev_obs);
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs;
      if (pop) begin
        if (exp_q.size() == 0) check("extra_transfer", nx + 1, total);
        else begin
          want = exp_q.pop_front();
          check("pixel", {11'b0, out_last, out_y, out_x, out_data}, want);
          if (rmode == 0) check("no_bubble", k, 3 + nx);
        end
        nx++;
        last_k = k;
        if (nx == rst_after) stop = 1;
      end
      if (!stop) begin
        if (done === 1'b1 && done_k < 0) begin
          done_k = k;
          check("done_cycle", k, (total == 0) ? 1 : last_k + 1);
        end else if (done_k >= 0 && k == done_k + 1) begin
          check("done_one_cycle", 32'(done), 32'd0);
          check("idle_after_done", 32'(busy), 32'd0);
          check("checksum", 32'(checksum), 32'(exp_sum & 16'hFFFF));
          stop = 1;
        end
      end
      if (!stop) begin
        @(posedge CLK); #1;
        k++;
        out_ready = ready_for(rmode, k);
        start = (k == restart_k);
        if (k == restart_k) begin
          TW = 6'd7; TH = 6'd9;
        end
      end
    end

    if (rst_after < 0) begin
      if (done_k < 0) check("done_timeout", done_k, k);
      check("reads_issued", issued, total);
      check("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
      check("all_pixels_seen", exp_q.size(), 0);
      repeat (2) @(negedge CLK);
      check("checksum_hold", 32'(checksum), 32'(exp_sum & 16'hFFFF));
    end
  endtask

  initial begin
    int hits;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals();
    @(posedge CLK); #1;
    RST = 1'b1;

    run_frame(4, 3, 0, 0, -1, -1);   // reference frame, ready held high
    run_frame(4, 3, 1, 0, -1, -1);   // same frame with a stalling consumer
    run_frame(0, 5, 0, 0, -1, -1);   // empty frame: zero width
    run_frame(7, 0, 0, 0, -1, -1);   // empty frame: zero height
    run_frame(5, 4, 0, 2, 6, -1);    // start pulsed mid-frame is ignored
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), 2, 2, -1, -1);
    run_frame(1, 1, 2, 2, -1, -1);
    run_frame(63, 63, 0, 1, -1, -1); // largest frame, every pixel 0xFF

    // Reset after the fifth transfer abandons the frame.
    run_frame(4, 3, 0, 0, -1, 5);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_vals();
    hits = 0;
    repeat (6) begin
      @(negedge CLK);
      if (done === 1'b1) hits++;
    end
    check("no_done_after_reset", hits, 0);
    run_frame(4, 3, 2, 2, -1, -1);   // clean frame after the abort

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
